bus_slave_serial: RTL and testbench
===================================

# bus_slave_serial

Serial bus slave port directly downstream of `uart_to_bus`. It accepts the 14-bit address / 8-bit data serial frame the master drives onto the bus (`valid_s`, `write_en_slave`, `addr_tx`, `data_tx`). It matches the 2-bit slave ID, then writes to or reads from a local byte memory. Read data is returned serially.

## Interface
- `SLAVE_ID`, 2'b10: device select, compared against the top 2 address bits.
- `MEM_AW`, 12: local memory address width, equal to the 12 low address bits.
- `DATA_W`, 8: data width.
- `clk` in 1: bus clock. One clock domain; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_s` in 1: frame valid from the master. Low mid-frame means pause (split).
- `write_en` in 1: 1 = write, 0 = read. Sampled on the start cycle.
- `addr_rx` in 1: serial address, MSB first.
- `data_rx` in 1: serial write data, MSB first.
- `slave_ready` out 1: high only in IDLE. The arbiter must not start a frame when it is low.
- `wr_done` out 1: one-cycle pulse when a write commits.
- `rd_valid` out 1: high during the 8 read-data bit cycles.
- `rdata_tx` out 1: serial read data, MSB first.

## Operation
- **Sample rule:** a bit is sampled only on a cycle where `valid_s`=1 and `valid_s` was also 1 on the previous cycle (`valid_q`). Every cycle where `valid_s` rises 0→1 carries no data; this applies to both the frame start and each resume after a pause.
- **Frame layout:** start cycle, then 6 address-only bits, then 8 cycles that each carry one address bit and one data bit. Total 14 address bits and 8 data bits.
- **States:**
  - IDLE: on `valid_s`=1, latch `write_en`, clear `bit_cnt`, go to ADDR.
  - ADDR: shift `addr_rx` on each sample; `bit_cnt` 0→5. After 2 bits, if `addr[13:12]`≠`SLAVE_ID`, set `miss`. After sample 6, go to ADDR_DATA.
  - ADDR_DATA: shift both `addr_rx` and `data_rx`; `bit_cnt` 6→13. After sample 14:
    - `miss`=1 → DRAIN.
    - write → COMMIT.
    - read → RD_FETCH.
  - COMMIT: write `mem[addr[11:0]]` ← data, pulse `wr_done`, go to DRAIN.
  - RD_FETCH: synchronous memory read, 1 cycle, load the shift register, go to READOUT.
  - READOUT: drive `rdata_tx`=`shreg[7]` with `rd_valid`=1 for 8 cycles, shifting left; then go to DRAIN.
  - DRAIN: wait until `valid_s`=0, then go to IDLE. This guarantees the tail of a frame is never taken as a new start.
- **Pause:** while `valid_s`=0 in ADDR or ADDR_DATA, hold the state, counter and shift registers.
- **ID mismatch:** the rest of the frame is still counted but ignored. No memory access, no `wr_done`, no `rd_valid`.
- **Data bits in a read frame:** ignored.
- **Memory:** not cleared by reset.

## Timing
- **Reset values:** `slave_ready`=1, `wr_done`=0, `rd_valid`=0, `rdata_tx`=0, state IDLE, counters 0.
- **Reset mid-frame:** return to IDLE on the next edge. The partial frame is discarded and memory is untouched.
- **Write latency:** `wr_done` goes high 1 cycle after the cycle carrying the 14th sample.
- **Read latency:** the first `rdata_tx` bit appears 2 cycles after the 14th sample. `rd_valid` stays high for exactly 8 consecutive cycles.
- **`slave_ready`:** falls the cycle after `valid_s` is first seen in IDLE. It returns high the cycle after DRAIN sees `valid_s`=0.
- **Simultaneous events:** `valid_s` dropping on the 14th-sample cycle means that sample is not taken; the counter holds.
- **Counters:** `bit_cnt` is 4 bits with no wrap; its range is 0..14.

## Structure
- **Shared package `bus_pkg`:**
  - Frame constants: `ADDR_W`=14, `DATA_W`=8, `ID_W`=2, `ADDR_ONLY_BITS`=6.
  - State encoding localparams.
  - These are shared with `uart_to_bus` and the arbiter.
- **Sub-module `slave_mem`:** single-port, 2^`MEM_AW`×`DATA_W`, synchronous write and synchronous read.
- **Control:** FSM, shift registers and counter live in `bus_slave_serial`.

## Test plan
- **Write:** write frame addr 14'b10_0000_0000_0101, data 8'hA5, `valid_s` continuous → `wr_done` pulses once. A following read frame to the same address returns `rdata_tx` 1,0,1,0,0,1,0,1 with `rd_valid` high 8 cycles.
- **Split:** write frame 8'h3C to addr 10_…_0011 with `valid_s` low for 5 cycles after address bit 2, then resumed with the re-start cycle → write lands correctly. A readback gives 8'h3C.
- **ID mismatch:** frame with top bits 2'b01 → no `wr_done`, no `rd_valid`, and memory unchanged on readback. `slave_ready` returns to 1 after `valid_s` falls.
- **Reset mid-frame:** `reset` after 9 samples → IDLE and `slave_ready`=1 the next cycle, no write. The next full frame works normally.
- **Back-to-back:** new frame started the cycle after `slave_ready` rises, writing 8'hFF then 8'h00 to adjacent addresses → both commit, and readbacks match.

Source files
------------

// File: rtl/bus_pkg.sv
// Frame constants and state encoding shared by the serial bus master, arbiter and slaves.
// Also holds the small slave-select helper used during address decode.
package bus_pkg;

  localparam int ADDR_W         = 14;
  localparam int DATA_W         = 8;
  localparam int ID_W           = 2;
  localparam int ADDR_ONLY_BITS = 6;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_DATA = 3'd2;
  localparam logic [2:0] S_COMMIT    = 3'd3;
  localparam logic [2:0] S_RD_FETCH  = 3'd4;
  localparam logic [2:0] S_READOUT   = 3'd5;
  localparam logic [2:0] S_DRAIN     = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_ADDR      = S_ADDR,
    ST_ADDR_DATA = S_ADDR_DATA,
    ST_COMMIT    = S_COMMIT,
    ST_RD_FETCH  = S_RD_FETCH,
    ST_READOUT   = S_READOUT,
    ST_DRAIN     = S_DRAIN
  } state_e;

  function automatic logic id_match(input logic [ID_W-1:0] id_bits,
                                    input logic [ID_W-1:0] sel);
    return (id_bits == sel);
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port byte memory behind the serial slave: synchronous write, registered read.
// Contents are deliberately not reset.
module slave_mem
  import bus_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_slave_serial.sv
// Serial bus slave: deserialises the 14-bit address / 8-bit data frame, decodes the
// slave ID, writes or reads local memory and returns read data serially, MSB first.
module bus_slave_serial
  import bus_pkg::*;
#(
  parameter logic [ID_W-1:0] SLAVE_ID = 2'b10,
  parameter int              MEM_AW   = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_s,
  input  logic write_en,
  input  logic addr_rx,
  input  logic data_rx,
  output logic slave_ready,
  output logic wr_done,
  output logic rd_valid,
  output logic rdata_tx
);

  state_e            r_state;
  state_e            w_next;
  logic              r_valid_q;
  logic              r_we;
  logic              r_miss;
  logic [3:0]        r_bit_cnt;
  logic [2:0]        r_out_cnt;
  logic [MEM_AW-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_shreg;
  logic              r_slave_ready;
  logic              r_wr_done;
  logic              r_rd_valid;

  logic              w_sample;
  logic              w_last_addr_only;
  logic              w_last_bit;
  logic              w_mem_we;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_rdata;

  // A rising edge of valid_s (start or resume) never carries a bit.
  assign w_sample         = valid_s & r_valid_q;
  assign w_last_addr_only = (r_bit_cnt == 4'(ADDR_ONLY_BITS - 1));
  assign w_last_bit       = (r_bit_cnt == 4'(ADDR_W - 1));
  assign w_mem_we         = (r_state == ST_COMMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (valid_s) w_next = ST_ADDR;
        else         w_next = ST_IDLE;
      end
      ST_ADDR: begin
        if (w_sample && w_last_addr_only) w_next = ST_ADDR_DATA;
        else                              w_next = ST_ADDR;
      end
      ST_ADDR_DATA: begin
        if (w_sample && w_last_bit) begin
          if (r_miss)    w_next = ST_DRAIN;
          else if (r_we) w_next = ST_COMMIT;
          else           w_next = ST_RD_FETCH;
        end else begin
          w_next = ST_ADDR_DATA;
        end
      end
      ST_COMMIT:   w_next = ST_DRAIN;
      ST_RD_FETCH: w_next = ST_READOUT;
      ST_READOUT: begin
        if (r_out_cnt == 3'd7) w_next = ST_DRAIN;
        else                   w_next = ST_READOUT;
      end
      ST_DRAIN: begin
        if (!valid_s) w_next = ST_IDLE;
        else          w_next = ST_DRAIN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // On the final sample cycle, present the completed address so read data is ready in RD_FETCH.
  always_comb begin
    w_mem_addr = r_addr;
    if (r_state == ST_ADDR_DATA) w_mem_addr = {r_addr[MEM_AW-2:0], addr_rx};
    else                         w_mem_addr = r_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_valid_q     <= 1'b0;
      r_we          <= 1'b0;
      r_miss        <= 1'b0;
      r_bit_cnt     <= 4'd0;
      r_out_cnt     <= 3'd0;
      r_addr        <= '0;
      r_data        <= '0;
      r_shreg       <= '0;
      r_slave_ready <= 1'b1;
      r_wr_done     <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_valid_q     <= valid_s;
      r_slave_ready <= (w_next == ST_IDLE);
      r_wr_done     <= (w_next == ST_COMMIT);
      r_rd_valid    <= (w_next == ST_READOUT);
      case (r_state)
        ST_IDLE: begin
          if (valid_s) begin
            r_we      <= write_en;
            r_bit_cnt <= 4'd0;
            r_miss    <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (w_sample) begin
            r_addr    <= {r_addr[MEM_AW-2:0], addr_rx};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if ((r_bit_cnt == 4'd1) && !id_match({r_addr[0], addr_rx}, SLAVE_ID)) begin
              r_miss <= 1'b1;
            end
          end
        end
        ST_ADDR_DATA: begin
          if (w_sample) begin
            r_addr    <= {r_addr[MEM_AW-2:0], addr_rx};
            r_data    <= {r_data[DATA_W-2:0], data_rx};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        ST_RD_FETCH: begin
          r_shreg   <= w_mem_rdata;
          r_out_cnt <= 3'd0;
        end
        ST_READOUT: begin
          r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
          r_out_cnt <= r_out_cnt + 3'd1;
        end
        default: begin
          r_out_cnt <= r_out_cnt;
        end
      endcase
    end
  end

  slave_mem #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (r_data),
    .o_rdata (w_mem_rdata)
  );

  assign slave_ready = r_slave_ready;
  assign wr_done     = r_wr_done;
  assign rd_valid    = r_rd_valid;
  assign rdata_tx    = r_shreg[DATA_W-1];

endmodule

// File: tb/tb_bus_slave_serial.sv
// Scoreboard bench for bus_slave_serial: a driver issues serial frames (with pauses and junk on
// non-sampled cycles), a byte-array model predicts responses, and a monitor checks them.
module tb_bus_slave_serial;

  logic clk = 1'b0;
  logic reset, valid_s, write_en, addr_rx, data_rx;
  logic slave_ready, wr_done, rd_valid, rdata_tx;

  bus_slave_serial #(.SLAVE_ID(2'b10), .MEM_AW(12)) dut (
    .clk(clk), .reset(reset), .valid_s(valid_s), .write_en(write_en),
    .addr_rx(addr_rx), .data_rx(data_rx), .slave_ready(slave_ready),
    .wr_done(wr_done), .rd_valid(rd_valid), .rdata_tx(rdata_tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem_model [int];
  int         cyc = 0;
  int         n_total = 0;
  int         n_pass = 0;
  int         rd_run = 0;
  int         rd_start = 0;
  logic [7:0] rd_bits = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!slave_ready && k < 60) begin
      tick();
      k++;
    end
    if (!slave_ready) chk("ready_timeout", 32'(slave_ready), 32'd1);
  endtask

  // Drive one frame; pause_at = number of samples after which valid_s drops for pause_len cycles.
  task automatic send_frame(input logic we, input logic [13:0] addr, input logic [7:0] data,
                            input int pause_at, input int pause_len);
    int key;
    wait_ready();
    valid_s  = 1'b1;
    write_en = we;
    addr_rx  = 1'($urandom_range(0, 1));
    data_rx  = 1'($urandom_range(0, 1));
    tick();
    chk("ready_fall", 32'(slave_ready), 32'd0);
    write_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < 14; i++) begin
      if (i == pause_at) begin
        for (int p = 0; p < pause_len; p++) begin
          valid_s = 1'b0;
          addr_rx = 1'($urandom_range(0, 1));
          data_rx = 1'($urandom_range(0, 1));
          tick();
        end
        valid_s = 1'b1;
        addr_rx = 1'($urandom_range(0, 1));
        data_rx = 1'($urandom_range(0, 1));
        tick();
      end
      valid_s = 1'b1;
      addr_rx = addr[13-i];
      if (i >= 6) data_rx = data[13-i];
      else        data_rx = 1'($urandom_range(0, 1));
      if (i == 13 && addr[13:12] == 2'b10) begin
        key = int'(addr[11:0]);
        if (we) begin
          mem_model[key] = data;
          sb_q.push_back('{is_rd: 1'b0, data: data, cyc: cyc + 1});
        end else if (mem_model.exists(key)) begin
          sb_q.push_back('{is_rd: 1'b1, data: mem_model[key], cyc: cyc + 2});
        end
      end
      tick();
    end
    valid_s = 1'b0;
    addr_rx = 1'b0;
    data_rx = 1'b0;
  endtask

  // Abort a write frame with reset after n_samples samples.
  task automatic reset_mid_frame(input logic [13:0] addr, input logic [7:0] data, input int n_samples);
    wait_ready();
    valid_s  = 1'b1;
    write_en = 1'b1;
    tick();
    for (int i = 0; i < n_samples; i++) begin
      addr_rx = addr[13-i];
      data_rx = (i >= 6) ? data[13-i] : 1'b0;
      tick();
    end
    valid_s = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    chk("rst_mid_ready", 32'(slave_ready), 32'd1);
    chk("rst_mid_wr_done", 32'(wr_done), 32'd0);
    chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a write or finishes a read burst.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset !== 1'b1) begin
      if (wr_done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_wr_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("wr_kind", 32'(e.is_rd), 32'd0);
          chk("wr_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (rd_valid) begin
        if (rd_run == 0) rd_start = cyc;
        rd_bits = {rd_bits[6:0], rdata_tx};
        rd_run++;
      end else if (rd_run != 0) begin
        chk("rd_valid_len", 32'(rd_run), 32'd8);
        if (sb_q.size() == 0) begin
          chk("spurious_rd_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rd_kind", 32'(e.is_rd), 32'd1);
          chk("rd_data", 32'(rd_bits), 32'(e.data));
          chk("rd_latency", 32'(rd_start), 32'(e.cyc));
        end
        rd_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a;
    logic        we;
    int          pa;
    reset = 1'b1; valid_s = 1'b0; write_en = 1'b0; addr_rx = 1'b0; data_rx = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(slave_ready), 32'd1);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rdata_tx", 32'(rdata_tx), 32'd0);
    reset = 1'b0;
    tick();

    // Basic write/readback, continuous valid.
    send_frame(1'b1, 14'b10_0000_0000_0101, 8'hA5, -1, 0);
    send_frame(1'b0, 14'b10_0000_0000_0101, 8'h00, -1, 0);
    // Split after address bit 2, with re-start cycle.
    send_frame(1'b1, 14'b10_0000_0000_0011, 8'h3C, 2, 5);
    send_frame(1'b0, 14'b10_0000_0000_0011, 8'h5A, 9, 3);
    // ID mismatch write/read, then verify memory untouched.
    send_frame(1'b1, 14'b01_0000_0000_0101, 8'h77, -1, 0);
    send_frame(1'b0, 14'b01_0000_0000_0101, 8'h00, -1, 0);
    send_frame(1'b0, 14'b10_0000_0000_0101, 8'h00, -1, 0);
    // Pause exactly where the 14th sample would be.
    send_frame(1'b1, 14'b10_0000_0000_0111, 8'hC3, 13, 2);
    send_frame(1'b0, 14'b10_0000_0000_0111, 8'h00, 13, 1);
    // Reset after 9 samples, then normal frames.
    reset_mid_frame(14'b10_0000_0000_0011, 8'h11, 9);
    send_frame(1'b0, 14'b10_0000_0000_0011, 8'h00, -1, 0);
    // Back-to-back writes to adjacent addresses.
    send_frame(1'b1, 14'b10_0000_0001_0000, 8'hFF, -1, 0);
    send_frame(1'b1, 14'b10_0000_0001_0001, 8'h00, -1, 0);
    send_frame(1'b0, 14'b10_0000_0001_0000, 8'h00, -1, 0);
    send_frame(1'b0, 14'b10_0000_0001_0001, 8'h00, -1, 0);

    // Random traffic over a small address window.
    for (int n = 0; n < 30; n++) begin
      a[11:0] = 12'h100 + 12'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a[13:12] = 2'b10;
      else                           a[13:12] = 2'($urandom_range(0, 1)) | 2'b01;
      we = 1'($urandom_range(0, 1));
      if (!we && a[13:12] == 2'b10 && !mem_model.exists(int'(a[11:0]))) we = 1'b1;
      pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 13)) : -1;
      send_frame(we, a, 8'($urandom_range(0, 255)), pa, int'($urandom_range(1, 4)));
    end

    wait_ready();
    repeat (5) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("rd_burst_closed", 32'(rd_run), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
